// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master: FSM states,
// quarter-phase encoding inside one SCL bit period, and bit-counter sizing.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_NACK,
        ST_STOP
    } i2c_state_e;

    typedef enum logic [1:0] {
        PH_Q0 = 2'd0,
        PH_Q1 = 2'd1,
        PH_Q2 = 2'd2,
        PH_Q3 = 2'd3
    } i2c_phase_e;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_W);

    function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == BIT_CNT_W'(BYTE_W - 1);
    endfunction

endpackage

// File: rtl/i2c_scl_tick.sv
// Quarter-period tick generator: pulses every CLK_DIV clocks while enabled and
// steps a 2-bit phase through Q0..Q3; held at zero whenever disabled.
module i2c_scl_tick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       tick,
    output i2c_phase_e phase
);

    localparam int               CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt   <= '0;
            phase <= PH_Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= i2c_phase_e'(phase + 2'd1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+rw, ACK, one data byte, ACK/NACK, STOP.
// Both bus lines are open-drain; the FSM only ever asserts pull-down enables.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl
);

    i2c_state_e           state;
    i2c_phase_e           phase;
    logic                 tick;
    logic                 sda_oe;
    logic                 scl_oe;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic [7:0]           wdata_q;
    logic                 rw_q;
    logic                 ack_smp;
    logic                 sda_meta;
    logic                 sda_in;

    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign scl = scl_oe ? 1'b0 : 1'bz;

    i2c_scl_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .tick (tick),
        .phase(phase)
    );

    // SDA comes from the pad asynchronously; sampling happens mid-high so two flops of delay are harmless
    always_ff @(posedge clk) begin
        sda_meta <= sda;
        sda_in   <= sda_meta;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sda_oe  <= 1'b0;
            scl_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                sda_oe <= 1'b0;
                scl_oe <= 1'b0;
                if (start) begin
                    shreg   <= {addr, rw};
                    rw_q    <= rw;
                    wdata_q <= wdata;
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    state   <= ST_START;
                end
            end else if (tick) begin
                unique case (phase)
                    PH_Q0: begin
                        scl_oe <= 1'b0;
                        if (state == ST_START) sda_oe <= 1'b1;
                    end
                    PH_Q1: begin
                    end
                    PH_Q2: begin
                        ack_smp <= sda_in;
                        if (state == ST_RD_DATA) shreg <= {shreg[6:0], sda_in};
                        // STOP keeps SCL high and lets SDA rise; every other bit pulls SCL low
                        if (state == ST_STOP) sda_oe <= 1'b0;
                        else                  scl_oe <= 1'b1;
                    end
                    PH_Q3: begin
                        case (state)
                            ST_START: begin
                                state   <= ST_ADDR;
                                bit_cnt <= '0;
                                sda_oe  <= ~shreg[7];
                            end
                            ST_ADDR, ST_WR_DATA: begin
                                if (is_last_bit(bit_cnt)) begin
                                    state  <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                                    sda_oe <= 1'b0;
                                end else begin
                                    shreg   <= {shreg[6:0], 1'b0};
                                    sda_oe  <= ~shreg[6];
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_ADDR_ACK: begin
                                bit_cnt <= '0;
                                if (ack_smp) begin
                                    ack_err <= 1'b1;
                                    state   <= ST_STOP;
                                    sda_oe  <= 1'b1;
                                end else if (rw_q) begin
                                    state  <= ST_RD_DATA;
                                    sda_oe <= 1'b0;
                                end else begin
                                    state  <= ST_WR_DATA;
                                    shreg  <= wdata_q;
                                    sda_oe <= ~wdata_q[7];
                                end
                            end
                            ST_WR_ACK: begin
                                ack_err <= ack_smp;
                                state   <= ST_STOP;
                                sda_oe  <= 1'b1;
                            end
                            ST_RD_DATA: begin
                                if (is_last_bit(bit_cnt)) begin
                                    state  <= ST_RD_NACK;
                                    rdata  <= shreg;
                                    sda_oe <= 1'b0;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            ST_RD_NACK: begin
                                state  <= ST_STOP;
                                sda_oe <= 1'b1;
                            end
                            ST_STOP: begin
                                state  <= ST_IDLE;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                sda_oe <= 1'b0;
                                scl_oe <= 1'b0;
                            end
                            default: begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: behavioural slave at 0x2A on pulled-up lines,
// scoreboard of expected bus bytes and completion results per transaction.
`timescale 1ns/1ps
module tb_i2c_master_controller;

    localparam int         CLK_DIV  = 4;
    localparam int         LAT_FULL = 80 * CLK_DIV;
    localparam int         LAT_NACK = 44 * CLK_DIV;
    localparam logic [6:0] SLV_ADDR = 7'h2A;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr  = '0;
    logic       rw    = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        sda;
    wire        scl;
    logic       slv_oe = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = slv_oe ? 1'b0 : 1'bz;

    i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .addr   (addr),
        .rw     (rw),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .ack_err(ack_err),
        .sda    (sda),
        .scl    (scl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
        n_tests++;
        if (obs < exp - tol || obs > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Slave model: counts START/STOP, logs each byte with its ACK-slot level as {byte, ack}
    logic       p_sda  = 1'b1;
    logic       p_scl  = 1'b1;
    logic       in_txn = 1'b0;
    logic       match  = 1'b0;
    logic       rdm    = 1'b0;
    logic [7:0] sh     = '0;
    logic [7:0] mem    = '0;
    int         bit_i  = 0;
    int         byte_i = 0;
    int         n_start = 0;
    int         n_stop  = 0;
    int         n_done  = 0;
    int         bus_q[$];

    always @(posedge clk) begin
        p_sda <= sda;
        p_scl <= scl;
        if (!rst_n) begin
            slv_oe <= 1'b0;
            bit_i  <= 0;
            byte_i <= 0;
            in_txn <= 1'b0;
        end else if (p_scl && scl && p_sda && !sda) begin
            n_start <= n_start + 1;
            in_txn  <= 1'b1;
            bit_i   <= 0;
            byte_i  <= 0;
            slv_oe  <= 1'b0;
        end else if (p_scl && scl && !p_sda && sda) begin
            n_stop <= n_stop + 1;
            in_txn <= 1'b0;
            slv_oe <= 1'b0;
        end else if (in_txn && !p_scl && scl) begin
            if (bit_i < 8) begin
                sh    <= {sh[6:0], sda};
                bit_i <= bit_i + 1;
            end else if (bit_i == 8) begin
                bus_q.push_back(int'({sh, sda}));
                bit_i <= 9;
            end
        end else if (in_txn && p_scl && !scl) begin
            if (bit_i == 8) begin
                if (byte_i == 0) begin
                    match  <= (sh[7:1] == SLV_ADDR);
                    rdm    <= sh[0];
                    slv_oe <= (sh[7:1] == SLV_ADDR);
                end else if (byte_i == 1 && match && !rdm) begin
                    mem    <= sh;
                    slv_oe <= 1'b1;
                end else begin
                    slv_oe <= 1'b0;
                end
            end else if (bit_i == 9) begin
                bit_i  <= 0;
                byte_i <= byte_i + 1;
                slv_oe <= (byte_i == 0 && match && rdm) ? !mem[7] : 1'b0;
            end else if (bit_i >= 1 && bit_i <= 7 && byte_i == 1 && match && rdm) begin
                slv_oe <= !mem[7 - bit_i];
            end
        end
    end

    always @(posedge clk) if (done) n_done <= n_done + 1;

    typedef struct {
        int ack_err;
        int rdata;
        int lat;
    } txn_t;

    txn_t       exp_q[$];
    int         exp_bus[$];
    logic [7:0] mem_model   = '0;
    logic [7:0] rdata_model = '0;

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d, input bit poke);
        txn_t t;
        int   lat, s0, p0, d0, e, o;
        bit   hit;
        hit = (a == SLV_ADDR);
        exp_bus.push_back(int'({a, r, ~hit}));
        if (hit) begin
            if (r) begin
                exp_bus.push_back(int'({mem_model, 1'b1}));
                rdata_model = mem_model;
            end else begin
                exp_bus.push_back(int'({d, 1'b0}));
                mem_model = d;
            end
        end
        t.ack_err = hit ? 0 : 1;
        t.rdata   = int'(rdata_model);
        t.lat     = hit ? LAT_FULL : LAT_NACK;
        exp_q.push_back(t);

        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        @(negedge clk);
        s0 = n_start; p0 = n_stop; d0 = n_done;
        start = 1'b1; addr = a; rw = r; wdata = d;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on_accept", busy, 1);
        chk("ack_err_clear", ack_err, 0);

        lat = -1;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (poke) begin
                start = (k == 200);
                if (k == 200) begin addr = 7'h11; rw = 1'b1; end
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;

        t = exp_q.pop_front();
        if (lat < 0) begin
            chk("done_timeout", 0, 1);
            exp_bus.delete();
            bus_q.delete();
            return;
        end
        chk("latency", lat, t.lat, 2);
        chk("ack_err", ack_err, t.ack_err);
        chk("rdata", rdata, t.rdata);
        chk("busy_at_done", busy, 0);
        repeat (4) @(negedge clk);
        chk("done_count", n_done - d0, 1);
        chk("start_count", n_start - s0, 1);
        chk("stop_count", n_stop - p0, 1);
        chk("bus_len", bus_q.size(), exp_bus.size());
        while (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            o = (bus_q.size() > 0) ? bus_q.pop_front() : -1;
            chk("bus_byte_ack", o, e);
        end
        bus_q.delete();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sda", sda, 1);
        chk("rst_scl", scl, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_txn(SLV_ADDR, 1'b0, 8'hA5, 1'b0);
        run_txn(SLV_ADDR, 1'b1, 8'h00, 1'b0);
        run_txn(7'h11,    1'b0, 8'h77, 1'b0);
        run_txn(SLV_ADDR, 1'b0, 8'h3C, 1'b0);
        run_txn(SLV_ADDR, 1'b1, 8'hFF, 1'b0);

        // Abort a write during address bit 3 while SCL is held low
        @(negedge clk);
        start = 1'b1; addr = SLV_ADDR; rw = 1'b0; wdata = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        repeat (77) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sda", sda, 1);
        chk("midrst_scl", scl, 1);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("midrst_rdata", rdata, 0);
        rst_n = 1'b1;
        rdata_model = '0;
        bus_q.delete();
        repeat (3) @(negedge clk);

        run_txn(SLV_ADDR, 1'b0, 8'hA5, 1'b0);
        run_txn(SLV_ADDR, 1'b0, 8'hA5, 1'b1);
        run_txn(SLV_ADDR, 1'b1, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_master_controller.md
I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

Interface
REQ-001 Parameter CLK_DIV, default 250, clk cycles per SCL quarter-period; legal values are 2 or greater.
REQ-002 clk  input  1  sole system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  transaction request, sampled when busy=0.
REQ-005 addr  input  7  target slave address, captured on accept.
REQ-006 rw  input  1  0=write byte to slave, 1=read byte from slave; captured on accept.
REQ-007 wdata  input  8  write byte, captured on accept.
REQ-008 rdata  output  8  last byte read from slave.
REQ-009 busy  output  1  high from cycle after accept until done.
REQ-010 done  output  1  one-cycle pulse at end of transaction.
REQ-011 ack_err  output  1  slave NACKed the address or write data; valid with done.
REQ-012 sda  inout  1  open-drain data: driven 0 or released to Z, never driven 1.
REQ-013 scl  inout  1  open-drain clock: driven 0 or released to Z.

Function
REQ-014 Single-byte transaction: START, addr+rw byte MSB first, ACK bit, one data byte, ACK/NACK bit, STOP.
REQ-015 Quarter tick every CLK_DIV clk cycles; each bit = 4 quarters: Q0 SCL low with SDA updated, Q1 SCL released, Q2 SDA sampled, Q3 SCL low.
REQ-016 States: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP.
REQ-017 IDLE: SDA/SCL released, busy=0. start=1 captures inputs and moves to START.
REQ-018 START: SDA pulled low while SCL released; after 1 bit-period go to ADDR with SCL low.
REQ-019 ADDR: shift {addr,rw} out MSB first over 8 bits, then go to ADDR_ACK.
REQ-020 ADDR_ACK: release SDA and sample at Q2. On 0 go to WR_DATA (rw=0) or RD_DATA (rw=1). On 1 set ack_err and go to STOP.
REQ-021 WR_DATA: shift wdata MSB first, then go to WR_ACK. WR_ACK: sample; a 1 sets ack_err. Always go to STOP.
REQ-022 RD_DATA: keep SDA released and shift in 8 bits MSB first at Q2. RD_NACK: release SDA (NACK), load rdata, go to STOP.
REQ-023 STOP: SDA low, SCL released, then SDA released while SCL is high. done pulses next cycle, busy=0, return to IDLE.
REQ-024 Latency: a full transaction is 20 bit-periods (80*CLK_DIV clk cycles, within ±2 cycles) from accept to done. An address NACK shortens it to 11 bit-periods.
REQ-025 start while busy=1 is ignored; there is no queueing.
REQ-026 ack_err clears on the next accepted start. rdata holds its value on write transactions and on address NACK.
REQ-027 SCL clock stretching is not supported: the master does not sample SCL.

Reset
REQ-028 While rst_n=0 at a clk edge: state=IDLE, SDA/SCL released, busy=0, done=0, ack_err=0, rdata=0x00, divider counter=0.
REQ-029 Reset mid-transaction releases both lines on the next clk edge and issues no STOP; the next start begins cleanly.

Structure
REQ-030 Shared package i2c_pkg holds the state enum, quarter-phase encoding and bit-count width constants.
REQ-031 One sub-module, i2c_scl_tick, generates the quarter tick and 2-bit phase from CLK_DIV and is reset by rst_n.
REQ-032 Open-drain tristates are only in the top module; internal signals are sda_oe/scl_oe, and asserting one drives 0.

Verification (CLK_DIV=4, 2 kΩ-equivalent pull-ups, paired with bench slave at 0x2A)
REQ-033 Write addr=0x2A, rw=0, wdata=0xA5 -> bus bytes 0x54, 0xA5, both ACKed. done after 320±2 cycles, ack_err=0.
REQ-034 Write 0xA5, then read addr=0x2A, rw=1 with slave returning 0xA5 -> bus byte 0x55, master NACKs the data, rdata=0xA5, ack_err=0.
REQ-035 Write to addr=0x11 (no responder) -> ack_err=1, STOP after address ACK slot, done after 176±2 cycles, rdata unchanged.
REQ-036 rst_n=0 during ADDR bit 3 -> sda=Z and scl=Z next edge, busy=0. A following write to 0x2A passes.
REQ-037 start pulsed during WR_DATA -> ignored; exactly one done, bus trace identical to REQ-033.
REQ-038 Protocol checker: SDA changes only while SCL is low, except START/STOP; no 1 is ever driven on sda or scl.
